// File: rtl/data_bus_arbiter_if.sv
// Signal bundle between the two data masters, the arbiter and the shared data-memory port.
// The arbiter connects through the slave modport; the masters and memory side use the master modport.
interface data_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_m0_req;
    logic                  i_m1_req;
    logic [ADDR_WIDTH-1:0] i_m0_addr;
    logic [ADDR_WIDTH-1:0] i_m1_addr;
    logic [1:0]            i_m0_access;
    logic [1:0]            i_m1_access;
    logic                  i_m0_wrEnable;
    logic                  i_m1_wrEnable;
    logic [DATA_WIDTH-1:0] i_m0_wrData;
    logic [DATA_WIDTH-1:0] i_m1_wrData;
    logic                  o_m0_gnt;
    logic                  o_m1_gnt;
    logic [DATA_WIDTH-1:0] o_m0_rdData;
    logic [DATA_WIDTH-1:0] o_m1_rdData;
    logic                  o_m0_rdValid;
    logic                  o_m1_rdValid;
    logic                  o_memEnable;
    logic [ADDR_WIDTH-1:0] o_memAddr;
    logic [1:0]            o_memAccess;
    logic                  o_memWrEnable;
    logic [DATA_WIDTH-1:0] o_memWrData;
    logic [DATA_WIDTH-1:0] i_memRdData;

    // Handshake: a master raises req with addr/access/wrEnable/wrData and holds them all stable
    // until it sees gnt high in the same cycle; that cycle the transfer is accepted and the
    // master may present its next transfer (or drop req) in the following cycle. Reads return
    // as a single-cycle rdValid pulse RD_LATENCY cycles after the grant; writes return nothing.
    modport slave (
        input  i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_access, i_m1_access,
        input  i_m0_wrEnable, i_m1_wrEnable, i_m0_wrData, i_m1_wrData, i_memRdData,
        output o_m0_gnt, o_m1_gnt, o_m0_rdData, o_m1_rdData, o_m0_rdValid, o_m1_rdValid,
        output o_memEnable, o_memAddr, o_memAccess, o_memWrEnable, o_memWrData
    );

    modport master (
        output i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_access, i_m1_access,
        output i_m0_wrEnable, i_m1_wrEnable, i_m0_wrData, i_m1_wrData, i_memRdData,
        input  o_m0_gnt, o_m1_gnt, o_m0_rdData, o_m1_rdData, o_m0_rdValid, o_m1_rdValid,
        input  o_memEnable, o_memAddr, o_memAccess, o_memWrEnable, o_memWrData
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data-memory port: registered owner, bounded bursts, tagged read return.
// Optional macro DBARB_M0_PRIORITY_EN gives master 0 fixed priority instead of symmetric round-robin.
module data_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    data_bus_arbiter_if.slave bus,
    output logic [1:0]        o_dbgState
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t                state;
    state_t                nextState;
    logic                  lastOwner;
    logic                  nextLastOwner;
    logic [3:0]            cnt;
    logic [3:0]            nextCnt;
    logic                  own;
    logic                  ownReq;
    logic                  otherReq;
    logic                  burstLimited;
    logic                  memEnable;
    logic                  selWrEnable;
    logic [1:0]            selAccess;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWrData;
    logic [RD_LATENCY-1:0] pipeValid;
    logic [RD_LATENCY-1:0] pipeTag;

    // own is only meaningful in OWN0/OWN1; in IDLE memEnable is low so it selects nothing.
    assign own      = (state == OWN1);
    assign ownReq   = own ? bus.i_m1_req : bus.i_m0_req;
    assign otherReq = own ? bus.i_m0_req : bus.i_m1_req;

`ifdef DBARB_M0_PRIORITY_EN
    assign burstLimited = own;
`else
    assign burstLimited = 1'b1;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            lastOwner <= 1'b1;
            cnt       <= 4'd0;
        end else begin
            state     <= nextState;
            lastOwner <= nextLastOwner;
            cnt       <= nextCnt;
        end
    end

    always_comb begin
        nextState     = state;
        nextLastOwner = lastOwner;
        nextCnt       = cnt;
        memEnable     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_m0_req && bus.i_m1_req) begin
`ifdef DBARB_M0_PRIORITY_EN
                    nextState = OWN0;
`else
                    nextState = lastOwner ? OWN0 : OWN1;
`endif
                end else if (bus.i_m0_req) begin
                    nextState = OWN0;
                end else if (bus.i_m1_req) begin
                    nextState = OWN1;
                end
            end
            OWN0, OWN1: begin
                memEnable = ownReq;
                // Hand over when the owner lets go, or when its burst quota expires on a grant.
                if (otherReq && (!ownReq || (burstLimited && cnt == BURST_LAST))) begin
                    nextState     = own ? OWN0 : OWN1;
                    nextLastOwner = own;
                    nextCnt       = 4'd0;
                end else if (!ownReq) begin
                    nextState     = IDLE;
                    nextLastOwner = own;
                    nextCnt       = 4'd0;
                end else if (otherReq && burstLimited) begin
                    nextCnt = cnt + 4'd1;
                end else begin
                    nextCnt = 4'd0;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        selWrEnable = 1'b0;
        selAccess   = 2'b00;
        selAddr     = '0;
        selWrData   = '0;
        if (state == OWN0) begin
            selWrEnable = bus.i_m0_wrEnable;
            selAccess   = bus.i_m0_access;
            selAddr     = bus.i_m0_addr;
            selWrData   = bus.i_m0_wrData;
        end else if (state == OWN1) begin
            selWrEnable = bus.i_m1_wrEnable;
            selAccess   = bus.i_m1_access;
            selAddr     = bus.i_m1_addr;
            selWrData   = bus.i_m1_wrData;
        end
    end

    assign bus.o_m0_gnt      = memEnable && !own;
    assign bus.o_m1_gnt      = memEnable && own;
    assign bus.o_memEnable   = memEnable;
    assign bus.o_memWrEnable = memEnable && selWrEnable;
    assign bus.o_memAccess   = selAccess;
    assign bus.o_memAddr     = selAddr;
    assign bus.o_memWrData   = selWrData;

    // Each accepted read travels alongside the memory latency carrying the issuing master's id.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pipeValid <= '0;
            pipeTag   <= '0;
        end else begin
            pipeValid[0] <= memEnable && !selWrEnable;
            pipeTag[0]   <= own;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeTag[i]   <= pipeTag[i-1];
            end
        end
    end

    assign bus.o_m0_rdValid = pipeValid[RD_LATENCY-1] && !pipeTag[RD_LATENCY-1];
    assign bus.o_m1_rdValid = pipeValid[RD_LATENCY-1] && pipeTag[RD_LATENCY-1];
    assign bus.o_m0_rdData  = bus.i_memRdData;
    assign bus.o_m1_rdData  = bus.i_memRdData;
    assign o_dbgState       = state;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed master transfers, a small memory model and a scoreboard
// of expected bus events (accesses and read returns) stamped with the cycle they must appear in.
module tb_data_bus_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RD_LAT = 2;
    localparam int MAX_B = 4;
    localparam int GNT_BUDGET = 20;
    // Event layout: cycle[15:0] | kind[2:0] | wrEnable | access[1:0] | addr | data
    // kind: 0 = access by m0, 1 = access by m1, 2 = read return m0, 3 = read return m1, 4 = malformed grant
    localparam int EW = 16 + 3 + 1 + 2 + AW + DW;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    int unsigned   cyc = 0;
    int            nChecks = 0;
    int            nFail = 0;
    logic [EW-1:0] exp_q[$];
    logic [1:0]    dbgState;
    logic [AW-1:0] memAddrPipe [RD_LAT];

    data_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_bus_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(RD_LAT),
        .MAX_BURST (MAX_B)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rstN),
        .bus       (bus),
        .o_dbgState(dbgState)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is a fixed function of the address sampled RD_LAT edges earlier.
    function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    always @(posedge clk) begin
        memAddrPipe[0] <= bus.o_memAddr;
        for (int i = 1; i < RD_LAT; i++) memAddrPipe[i] <= memAddrPipe[i-1];
    end
    assign bus.i_memRdData = memData(memAddrPipe[RD_LAT-1]);

    function automatic logic [EW-1:0] accEv(input int unsigned c, input logic m, input logic we,
                                            input logic [1:0] acc, input logic [AW-1:0] a,
                                            input logic [DW-1:0] d);
        return {c[15:0], {2'b00, m}, we, acc, a, d};
    endfunction

    function automatic logic [EW-1:0] rdEv(input int unsigned c, input logic m, input logic [DW-1:0] d);
        logic [2:0] kind;
        kind = m ? 3'd3 : 3'd2;
        return {c[15:0], kind, 1'b0, 2'b00, {AW{1'b0}}, d};
    endfunction

    // Scoreboard
    task automatic checkEvent(input string name, input logic [EW-1:0] got);
        logic [EW-1:0] exp;
        nChecks++;
        if (exp_q.size() == 0) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got event %h, expected no event", name, cyc, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                nFail++;
                $display("FAIL %s at cycle %0d: got %h, expected %h (cycle|kind|we|acc|addr|data)",
                         name, cyc, got, exp);
            end
        end
    endtask

    task automatic monitorSample();
        logic [2:0] kind;
        if (bus.o_memEnable || bus.o_memWrEnable || bus.o_m0_gnt || bus.o_m1_gnt) begin
            kind = (bus.o_memEnable && (bus.o_m0_gnt ^ bus.o_m1_gnt)) ? {2'b00, bus.o_m1_gnt} : 3'd4;
            checkEvent("access", {cyc[15:0], kind, bus.o_memWrEnable, bus.o_memAccess,
                                  bus.o_memAddr, bus.o_memWrData});
        end
        if (bus.o_m0_rdValid) checkEvent("rd_return_m0", rdEv(cyc, 1'b0, bus.o_m0_rdData));
        if (bus.o_m1_rdValid) checkEvent("rd_return_m1", rdEv(cyc, 1'b1, bus.o_m1_rdData));
    endtask

    task automatic checkQuiet(input string name);
        logic [6+2+AW+DW-1:0] outs;
        outs = {bus.o_m0_gnt, bus.o_m1_gnt, bus.o_m0_rdValid, bus.o_m1_rdValid, bus.o_memEnable,
                bus.o_memWrEnable, bus.o_memAccess, bus.o_memAddr, bus.o_memWrData};
        nChecks++;
        if (outs !== '0) begin
            nFail++;
            $display("FAIL %s outputs: got %h, expected all zero", name, outs);
        end
        nChecks++;
        if (dbgState !== 2'd0) begin
            nFail++;
            $display("FAIL %s state: got %0d, expected 0 (IDLE)", name, dbgState);
        end
    endtask

    task automatic drainCheck(input string name);
        repeat (8) @(posedge clk);
        #1;
        nChecks++;
        if (exp_q.size() != 0) begin
            nFail++;
            $display("FAIL %s drain: %0d expected events never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Driver tasks
    task automatic drive(input logic m, input logic req, input logic [AW-1:0] a, input logic [1:0] acc,
                         input logic we, input logic [DW-1:0] d);
        if (!m) begin
            bus.i_m0_req = req; bus.i_m0_addr = a; bus.i_m0_access = acc;
            bus.i_m0_wrEnable = we; bus.i_m0_wrData = d;
        end else begin
            bus.i_m1_req = req; bus.i_m1_addr = a; bus.i_m1_access = acc;
            bus.i_m1_wrEnable = we; bus.i_m1_wrData = d;
        end
    endtask

    task automatic idleMaster(input logic m);
        drive(m, 1'b0, '0, 2'b00, 1'b0, '0);
    endtask

    // Presents one transfer, holds it until granted, returns in the cycle after the grant.
    task automatic issue(input logic m, input logic [AW-1:0] a, input logic [1:0] acc,
                         input logic we, input logic [DW-1:0] d);
        int waited;
        waited = 0;
        drive(m, 1'b1, a, acc, we, d);
        @(negedge clk);
        while (!(m ? bus.o_m1_gnt : bus.o_m0_gnt) && waited < GNT_BUDGET) begin
            waited++;
            @(negedge clk);
        end
        nChecks++;
        if (waited >= GNT_BUDGET) begin
            nFail++;
            $display("FAIL grant_wait m%0d: no grant after %0d cycles, expected within %0d", m, waited, GNT_BUDGET);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        idleMaster(1'b0);
        idleMaster(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkQuiet("in_reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;
        idleMaster(1'b0);
        idleMaster(1'b1);
        fork
            forever begin
                @(negedge clk);
                if (rstN) monitorSample();
            end
        join_none

        applyReset();
        @(negedge clk);
        checkQuiet("after_reset");
        @(posedge clk);
        #1;

        // Single read from m0
        t = cyc;
        exp_q.push_back(accEv(t + 1, 1'b0, 1'b0, 2'b10, 32'h100, '0));
        exp_q.push_back(rdEv(t + 1 + RD_LAT, 1'b0, 32'hDEADBEEF));
        issue(1'b0, 32'h100, 2'b10, 1'b0, '0);
        idleMaster(1'b0);
        drainCheck("single_read");

        // Simultaneous first request after reset: m0 first, dead cycle, then m1
        applyReset();
        t = cyc;
        exp_q.push_back(accEv(t + 1, 1'b0, 1'b0, 2'b10, 32'h200, '0));
        exp_q.push_back(accEv(t + 3, 1'b1, 1'b0, 2'b10, 32'h300, '0));
        exp_q.push_back(rdEv(t + 3, 1'b0, memData(32'h200)));
        exp_q.push_back(rdEv(t + 5, 1'b1, memData(32'h300)));
        fork
            begin issue(1'b0, 32'h200, 2'b10, 1'b0, '0); idleMaster(1'b0); end
            begin issue(1'b1, 32'h300, 2'b10, 1'b0, '0); idleMaster(1'b1); end
        join
        drainCheck("simultaneous");

        // Burst: m0 streams six reads, m1 requests from the third cycle
        t = cyc;
`ifdef DBARB_M0_PRIORITY_EN
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(accEv(t + 1 + i, 1'b0, 1'b0, 2'b10, 32'h400 + 4 * i, '0));
            if (i >= 2) exp_q.push_back(rdEv(t + 1 + i, 1'b0, memData(32'h400 + 4 * (i - 2))));
        end
        exp_q.push_back(rdEv(t + 7, 1'b0, memData(32'h410)));
        exp_q.push_back(accEv(t + 8, 1'b1, 1'b0, 2'b10, 32'h500, '0));
        exp_q.push_back(rdEv(t + 8, 1'b0, memData(32'h414)));
        exp_q.push_back(rdEv(t + 10, 1'b1, memData(32'h500)));
`else
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(accEv(t + 1 + i, 1'b0, 1'b0, 2'b10, 32'h400 + 4 * i, '0));
            if (i >= 2) exp_q.push_back(rdEv(t + 1 + i, 1'b0, memData(32'h400 + 4 * (i - 2))));
        end
        exp_q.push_back(accEv(t + 6, 1'b1, 1'b0, 2'b10, 32'h500, '0));
        exp_q.push_back(rdEv(t + 6, 1'b0, memData(32'h40C)));
        exp_q.push_back(rdEv(t + 7, 1'b0, memData(32'h410)));
        exp_q.push_back(accEv(t + 8, 1'b0, 1'b0, 2'b10, 32'h414, '0));
        exp_q.push_back(rdEv(t + 8, 1'b1, memData(32'h500)));
        exp_q.push_back(rdEv(t + 10, 1'b0, memData(32'h414)));
`endif
        fork
            begin
                for (int i = 0; i < 6; i++) issue(1'b0, 32'h400 + 4 * i, 2'b10, 1'b0, '0);
                idleMaster(1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                issue(1'b1, 32'h500, 2'b10, 1'b0, '0);
                idleMaster(1'b1);
            end
        join
        drainCheck("burst");

        // m1 byte write racing an m0 write followed by a read
        t = cyc;
`ifdef DBARB_M0_PRIORITY_EN
        exp_q.push_back(accEv(t + 1, 1'b0, 1'b1, 2'b10, 32'h600, 32'hCAFE));
        exp_q.push_back(accEv(t + 2, 1'b0, 1'b0, 2'b10, 32'h604, '0));
        exp_q.push_back(accEv(t + 4, 1'b1, 1'b1, 2'b00, 32'h20, 32'h55));
        exp_q.push_back(rdEv(t + 4, 1'b0, memData(32'h604)));
`else
        exp_q.push_back(accEv(t + 1, 1'b1, 1'b1, 2'b00, 32'h20, 32'h55));
        exp_q.push_back(accEv(t + 3, 1'b0, 1'b1, 2'b10, 32'h600, 32'hCAFE));
        exp_q.push_back(accEv(t + 4, 1'b0, 1'b0, 2'b10, 32'h604, '0));
        exp_q.push_back(rdEv(t + 6, 1'b0, memData(32'h604)));
`endif
        fork
            begin
                issue(1'b0, 32'h600, 2'b10, 1'b1, 32'hCAFE);
                issue(1'b0, 32'h604, 2'b10, 1'b0, '0);
                idleMaster(1'b0);
            end
            begin issue(1'b1, 32'h20, 2'b00, 1'b1, 32'h55); idleMaster(1'b1); end
        join
        drainCheck("write");

        // Reset one cycle after a read grant, released before the data would return
        t = cyc;
        exp_q.push_back(accEv(t + 1, 1'b0, 1'b0, 2'b10, 32'h700, '0));
        issue(1'b0, 32'h700, 2'b10, 1'b0, '0);
        idleMaster(1'b0);
        rstN = 1'b0;
        @(negedge clk);
        checkQuiet("reset_mid_read");
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkQuiet("release_mid_read");
        drainCheck("reset_mid_read");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single data-memory port (addr/access/wrEnable/wrData/rdData) between the processor data port (master 0) and a secondary master such as a loader/DMA/debug port (master 1). Sits between `ProcessorSC`/`ProcessorPP` plus the secondary master on one side and the data memory on the other. Grants one transfer per cycle with a registered owner, bounded bursts and a read-return pipeline that tags data back to the issuing master.

## Interface
Parameters:
- `DATA_WIDTH`, `` `DATA_WIDTH`` (32): data bus width.
- `ADDR_WIDTH`, `` `ADDR_WIDTH`` (32): byte address width.
- `RD_LATENCY`, 1: cycles from accepted read to valid `i_memRdData`; legal range 1..4.
- `MAX_BURST`, 4: maximum consecutive grants to one owner while the other master is requesting; legal range 1..15.

Ports:
- `i_clock`  in  1  clock, all state on rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_m0_req`, `i_m1_req`  in  1  transfer request; address/control/data held stable until granted.
- `i_m0_addr`, `i_m1_addr`  in  ADDR_WIDTH  byte address.
- `i_m0_access`, `i_m1_access`  in  2  access size (DataAccess: byte/half/word).
- `i_m0_wrEnable`, `i_m1_wrEnable`  in  1  1 = write, 0 = read.
- `i_m0_wrData`, `i_m1_wrData`  in  DATA_WIDTH  write data.
- `o_m0_gnt`, `o_m1_gnt`  out  1  transfer accepted this cycle.
- `o_m0_rdData`, `o_m1_rdData`  out  DATA_WIDTH  read data (fan-out of `i_memRdData`).
- `o_m0_rdValid`, `o_m1_rdValid`  out  1  read data valid for that master.
- `o_memEnable`  out  1  memory access this cycle.
- `o_memAddr`  out  ADDR_WIDTH, `o_memAccess`  out  2, `o_memWrEnable`  out  1, `o_memWrData`  out  DATA_WIDTH  memory-side request.
- `i_memRdData`  in  DATA_WIDTH  memory read data.

## Operation
- FSM states: IDLE, OWN0, OWN1. Register `lastOwner` (reset 1), burst counter `cnt` (4 bits, reset 0).
- IDLE: no memory access. Single requester -> OWNk. Both -> owner = master != `lastOwner` (round-robin).
- OWNk: memory outputs muxed combinationally from master k; `o_memEnable = o_mk_gnt = i_mk_req`; other gnt = 0. `o_memWrEnable` gated by `o_memEnable`.
- OWNk next state, in priority order:
  - other req and (`!i_mk_req` or (`o_mk_gnt` and `cnt == MAX_BURST-1`)) -> OWN(other), `cnt` = 0, `lastOwner` = k.
  - `!i_mk_req` -> IDLE, `lastOwner` = k, `cnt` = 0.
  - else stay; `cnt` increments on gnt only when other is requesting, else held at 0.
- Read return: `RD_LATENCY`-deep shift of {valid, tag}; entry = {gnt && !wrEnable, owner}. `o_mk_rdValid` = pipe-out valid && tag == k.
- Writes produce no return. Master must not change inputs in a cycle its req is high and gnt low.

## Timing
- Reset (asserted low): state IDLE, all gnt/rdValid/memEnable/memWrEnable = 0, memAddr/memAccess/memWrData = 0, read pipe cleared; in-flight reads are dropped.
- Request latency: req rising at cycle N in IDLE -> gnt and memory access at N+1.
- Back-to-back: owner holding req gets one gnt per cycle; master presents next transfer the cycle after gnt.
- Read data: gnt at cycle G -> `o_mk_rdValid` = 1 and data at G+RD_LATENCY, single cycle.
- Owner handoff with owner req low: one dead cycle (OWNk, no access), other gnt next cycle. Burst preemption handoff: no dead cycle.
- Master with req high in OWN(other) waits; max wait = MAX_BURST + 1 cycles.

## Configuration
- `DBARB_M0_PRIORITY_EN`: defined -> master 0 has fixed priority: IDLE with both requesting picks master 0; OWN0 never preempted by burst limit; OWN1 preempted after MAX_BURST grants when master 0 requests. Undefined -> symmetric round-robin as above.

## Test plan
- Single read: reset, m0 req, addr 0x100, read, at cycle 0 -> cycle 1 gnt0, memAddr 0x100, memEnable 1; memRdData 0xDEADBEEF -> cycle 2 rdValid0 = 1, rdData0 0xDEADBEEF, rdValid1 = 0.
- Simultaneous first request after reset: both req -> m0 granted first; after m0 drops, dead cycle, then m1 granted.
- Burst limit: MAX_BURST = 4, m0 continuous reads, m1 req from cycle 2 -> exactly 4 consecutive gnt0 once m1 waits, then gnt1 next cycle without dead cycle, rdValid tags match issuer.
- Write: m1 write 0x55 to 0x20 -> memWrEnable 1 for exactly one cycle, no rdValid.
- Reset mid-read: assert reset one cycle after gnt0 with RD_LATENCY = 2 -> rdValid0 never asserts, outputs 0, IDLE on release.
- `DBARB_M0_PRIORITY_EN` defined: m0 continuous with m1 waiting -> m1 never granted; m1 owner for 4 grants then m0 preempts.
